radar_cfg_reg_map: RTL

Register-map write slave for the radar control path. It sits directly downstream of the DIP-switch command generator and consumes its `reg_map_wr_*` command bus. Each write is applied into a bank of 32-bit configuration registers under a per-bit mask, and the block returns a one-cycle response with an error code. The register contents (chirp mode in reg 0, bit 0) are exported as a flat bus, with per-register update strobes for downstream waveform and ADC logic.

---
 rtl/radar_cfg_reg_map.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/radar_cfg_reg_map.sv
// radar_cfg_reg_map: masked register-map write slave for the radar control path.
// Accepts one reg_map_wr_* command at a time (IDLE -> WRITE -> RESP), applies it
// under a per-bit keep mask and returns a one-cycle response with an error code.
// Optional build macro REG_MAP_SHADOW_EN: writes land in a shadow bank that is
// committed to the active registers on frame_sync. Without it, writes go straight
// to the active registers and frame_sync is unused.
module radar_cfg_reg_map #(
    parameter int                         REG_ADDR_WIDTH  = 8,
    parameter int                         CORE_DATA_WIDTH = 32,
    parameter int                         NUM_REGS        = 8,
    parameter int                         RO_ADDR         = 7,
    parameter logic [CORE_DATA_WIDTH-1:0] VERSION         = 32'h0001_0000
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                reg_map_wr_cmd,
    input  logic [REG_ADDR_WIDTH-1:0]           reg_map_wr_addr,
    input  logic [CORE_DATA_WIDTH-1:0]          reg_map_wr_data,
    input  logic [CORE_DATA_WIDTH-1:0]          reg_map_wr_keep,
    output logic                                reg_map_wr_ready,
    output logic                                reg_map_wr_valid,
    output logic [1:0]                          reg_map_wr_err,
    input  logic                                frame_sync,
    output logic [NUM_REGS*CORE_DATA_WIDTH-1:0] cfg_regs,
    output logic [NUM_REGS-1:0]                 cfg_update,
    output logic                                chirp_fast
);

    localparam int DW = CORE_DATA_WIDTH;
    localparam logic [31:0] NUM_REGS_U = NUM_REGS;
    localparam logic [31:0] RO_ADDR_U  = RO_ADDR;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_ADDR = 2'b01;
    localparam logic [1:0] ERR_RO   = 2'b10;
    localparam logic [1:0] ERR_KEEP = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RESP} state_t;
    typedef logic [NUM_REGS-1:0][DW-1:0] bank_t;

    // Reset image of a register bank: all zero except the version register.
    function automatic bank_t bank_init();
        bank_t b;
        for (int k = 0; k < NUM_REGS; k++) begin
            b[k] = (k == RO_ADDR) ? VERSION : '0;
        end
        return b;
    endfunction

    state_t                    state_q;
    logic                      ready_q, valid_q;
    logic [1:0]                err_q;
    logic [REG_ADDR_WIDTH-1:0] addr_q;
    logic [DW-1:0]             data_q, keep_q;
    logic [1:0]                code_d;
    logic [NUM_REGS-1:0]       wr_sel;
    bank_t                     regs_q, regs_d;
    logic [NUM_REGS-1:0]       chg_q, cfg_update_q;

    // Error decode of the latched command; priority addr range > read-only > empty mask.
    always_comb begin
        code_d = ERR_OK;
        if (32'(addr_q) >= NUM_REGS_U) begin
            code_d = ERR_ADDR;
        end else if (32'(addr_q) == RO_ADDR_U) begin
            code_d = ERR_RO;
        end else if (keep_q == '0) begin
            code_d = ERR_KEEP;
        end
    end

    // One-hot register select, only during WRITE and only for an error-free command.
    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            wr_sel[k] = (state_q == S_WRITE) && (code_d == ERR_OK) && (32'(addr_q) == 32'(k));
        end
    end

`ifdef REG_MAP_SHADOW_EN
    bank_t shadow_q, shadow_d;

    // Masked write into the shadow bank.
    always_comb begin
        shadow_d = shadow_q;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_sel[k]) begin
                shadow_d[k] = (shadow_q[k] & ~keep_q) | (data_q & keep_q);
            end
        end
    end

    // Commit takes the shadow value from before any same-cycle write.
    always_comb begin
        regs_d = frame_sync ? shadow_q : regs_q;
    end

    // Shadow bank storage.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            shadow_q <= bank_init();
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    logic unused_frame_sync;
    assign unused_frame_sync = frame_sync;

    // Masked write directly into the active bank.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_sel[k]) begin
                regs_d[k] = (regs_q[k] & ~keep_q) | (data_q & keep_q);
            end
        end
    end
`endif

    // Active bank plus change tracking; cfg_update trails the visible change by one cycle.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            regs_q       <= bank_init();
            chg_q        <= '0;
            cfg_update_q <= '0;
        end else begin
            regs_q <= regs_d;
            for (int k = 0; k < NUM_REGS; k++) begin
                chg_q[k] <= (regs_d[k] != regs_q[k]);
            end
            cfg_update_q <= chg_q;
        end
    end

    // Command FSM with registered handshake/response outputs; busy commands are dropped.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= ERR_OK;
            addr_q  <= '0;
            data_q  <= '0;
            keep_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    if (reg_map_wr_cmd) begin
                        addr_q  <= reg_map_wr_addr;
                        data_q  <= reg_map_wr_data;
                        keep_q  <= reg_map_wr_keep;
                        ready_q <= 1'b0;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    valid_q <= 1'b1;
                    err_q   <= code_d;
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign reg_map_wr_ready = ready_q;
    assign reg_map_wr_valid = valid_q;
    assign reg_map_wr_err   = err_q;
    assign cfg_regs         = regs_q;
    assign cfg_update       = cfg_update_q;
    assign chirp_fast       = regs_q[0][0];

endmodule
